stage_id: RTL and testbench

STAGE_ID -- requirements
Module: stage_id

---
 rtl/stage_id.sv | 218 +++++++++++++++++++++
 tb/tb_stage_id.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stage_id.sv
// Instruction decode stage: IF/ID pipeline register, 15-entry register file
// with write-through bypass, condition evaluation and control decode.
module stage_id #(
  parameter int unsigned NUM_REGS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instruction_in,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic [3:0]  status,
  output logic [31:0] pc_out,
  output logic [31:0] rn_val,
  output logic [31:0] rm_val,
  output logic        wb_en_out,
  output logic        mem_r_en,
  output logic        mem_w_en,
  output logic        branch,
  output logic        s_out,
  output logic        imm,
  output logic [3:0]  exe_cmd,
  output logic [11:0] shift_operand,
  output logic [23:0] signed_imm_24,
  output logic [3:0]  dest,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        two_src
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;

  // Data-processing opcodes (instr[24:21])
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // ALU commands
  localparam logic [3:0] EXE_NONE = 4'b0000;
  localparam logic [3:0] EXE_MOV  = 4'b0001;
  localparam logic [3:0] EXE_ADD  = 4'b0010;
  localparam logic [3:0] EXE_ADC  = 4'b0011;
  localparam logic [3:0] EXE_SUB  = 4'b0100;
  localparam logic [3:0] EXE_SBC  = 4'b0101;
  localparam logic [3:0] EXE_AND  = 4'b0110;
  localparam logic [3:0] EXE_ORR  = 4'b0111;
  localparam logic [3:0] EXE_EOR  = 4'b1000;
  localparam logic [3:0] EXE_MVN  = 4'b1001;

  logic [DW-1:0] pc_q;
  logic [DW-1:0] instr_q;
  logic          valid_q;
  logic [DW-1:0] rf [NUM_REGS];

  logic [3:0]    cond;
  logic [1:0]    mode;
  logic          i_bit;
  logic [3:0]    opcode;
  logic          s_bit;
  logic [RW-1:0] rn;
  logic [RW-1:0] rd;
  logic [RW-1:0] rm_idx;
  logic          wb_legal;
  logic          cond_ok;
  logic          exec_ok;

  logic [3:0]    cmd_d;
  logic          wb_d;
  logic          mr_d;
  logic          mw_d;
  logic          br_d;
  logic          s_d;

  // IF/ID register: flush beats freeze, freeze holds, otherwise capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (!freeze) begin
      pc_q    <= pc_in;
      instr_q <= instruction_in;
      valid_q <= 1'b1;
    end
  end

  assign wb_legal = wb_en && (32'(wb_dest) < NUM_REGS);

  // Register file: reset to R[i]=i; writes to R15 (PC) are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf[i] <= DW'(i);
    end else if (wb_legal) begin
      rf[wb_dest] <= wb_value;
    end
  end

  assign cond   = instr_q[31:28];
  assign mode   = instr_q[27:26];
  assign i_bit  = instr_q[25];
  assign opcode = instr_q[24:21];
  assign s_bit  = instr_q[20];
  assign rn     = instr_q[19:16];
  assign rd     = instr_q[15:12];
  assign rm_idx = mw_d ? rd : instr_q[3:0];

  // Rn read with same-cycle write-through bypass
  always_comb begin
    rn_val = '0;
    if (rst && wb_legal && (rn == wb_dest)) rn_val = wb_value;
    else if (32'(rn) < NUM_REGS)            rn_val = rf[rn];
  end

  // Rm read (Rd for stores) with same-cycle write-through bypass
  always_comb begin
    rm_val = '0;
    if (rst && wb_legal && (rm_idx == wb_dest)) rm_val = wb_value;
    else if (32'(rm_idx) < NUM_REGS)            rm_val = rf[rm_idx];
  end

  // Condition code evaluation against NZCV
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = status[2];
      4'h1: cond_ok = !status[2];
      4'h2: cond_ok = status[1];
      4'h3: cond_ok = !status[1];
      4'h4: cond_ok = status[3];
      4'h5: cond_ok = !status[3];
      4'h6: cond_ok = status[0];
      4'h7: cond_ok = !status[0];
      4'h8: cond_ok = status[1] && !status[2];
      4'h9: cond_ok = !status[1] || status[2];
      4'hA: cond_ok = (status[3] == status[0]);
      4'hB: cond_ok = (status[3] != status[0]);
      4'hC: cond_ok = !status[2] && (status[3] == status[0]);
      4'hD: cond_ok = status[2] || (status[3] != status[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Control decode by instruction class, before condition gating
  always_comb begin
    cmd_d = EXE_NONE;
    wb_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    br_d  = 1'b0;
    s_d   = 1'b0;
    case (mode)
      2'b00: begin
        s_d  = s_bit;
        wb_d = 1'b1;
        case (opcode)
          OP_MOV: cmd_d = EXE_MOV;
          OP_MVN: cmd_d = EXE_MVN;
          OP_ADD: cmd_d = EXE_ADD;
          OP_ADC: cmd_d = EXE_ADC;
          OP_SUB: cmd_d = EXE_SUB;
          OP_SBC: cmd_d = EXE_SBC;
          OP_AND: cmd_d = EXE_AND;
          OP_ORR: cmd_d = EXE_ORR;
          OP_EOR: cmd_d = EXE_EOR;
          OP_CMP: begin cmd_d = EXE_SUB; wb_d = 1'b0; end
          OP_TST: begin cmd_d = EXE_AND; wb_d = 1'b0; end
          default: cmd_d = EXE_NONE;
        endcase
      end
      2'b01: begin
        cmd_d = EXE_ADD;
        if (s_bit) begin
          mr_d = 1'b1;
          wb_d = 1'b1;
        end else begin
          mw_d = 1'b1;
        end
      end
      2'b10: br_d = 1'b1;
      default: ;
    endcase
  end

  // Side-effecting controls are squashed for bubbles and failed conditions
  assign exec_ok   = valid_q && cond_ok;
  assign wb_en_out = wb_d && exec_ok;
  assign mem_r_en  = mr_d && exec_ok;
  assign mem_w_en  = mw_d && exec_ok;
  assign branch    = br_d && exec_ok;
  assign s_out     = s_d  && exec_ok;

  assign exe_cmd       = cmd_d;
  assign imm           = i_bit;
  assign dest          = rd;
  assign src1          = rn;
  assign src2          = rm_idx;
  assign two_src       = !i_bit || mw_d;
  assign shift_operand = instr_q[11:0];
  assign signed_imm_24 = instr_q[23:0];
  assign pc_out        = pc_q;

endmodule

// File: tb/tb_stage_id.sv
// Directed self-checking bench for stage_id.
module tb_stage_id;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [3:0]  status;
  logic [31:0] pc_out;
  logic [31:0] rn_val;
  logic [31:0] rm_val;
  logic        wb_en_out;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        branch;
  logic        s_out;
  logic        imm;
  logic [3:0]  exe_cmd;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [3:0]  dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;

  int total = 0;
  int bad   = 0;

  stage_id #(.NUM_REGS(15)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .pc_in(pc_in), .instruction_in(instruction_in),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value), .status(status),
    .pc_out(pc_out), .rn_val(rn_val), .rm_val(rm_val),
    .wb_en_out(wb_en_out), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .branch(branch), .s_out(s_out), .imm(imm), .exe_cmd(exe_cmd),
    .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
    .dest(dest), .src1(src1), .src2(src2), .two_src(two_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {wb_en_out, mem_r_en, mem_w_en, branch, s_out}
  function automatic logic [4:0] ctrl();
    return {wb_en_out, mem_r_en, mem_w_en, branch, s_out};
  endfunction

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    pc_in = 32'h0000_0040; instruction_in = 32'hE281_1005;
    wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0; status = 4'b0000;
    #1;
    total++; if (pc_out !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
    tick();
    total++; if (ctrl() !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", ctrl()); end
    total++; if (imm !== 1'b0) begin bad++; $display("FAIL reset_imm got=%b exp=0", imm); end
    total++; if (pc_out !== 32'd0) begin bad++; $display("FAIL reset_pc_held got=%h exp=0", pc_out); end
    total++; if (rn_val !== 32'd0) begin bad++; $display("FAIL reset_rn got=%h exp=0", rn_val); end
  endtask

  task automatic test_read_all();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      pc_in = 32'h100 + 32'(i) * 4;
      instruction_in = 32'hEC00_0000 | (32'(i) << 16) | 32'(i);
      tick();
      total++; if (rn_val !== 32'(i)) begin bad++; $display("FAIL read_rn%0d got=%h exp=%h", i, rn_val, 32'(i)); end
      total++; if (rm_val !== 32'(i)) begin bad++; $display("FAIL read_rm%0d got=%h exp=%h", i, rm_val, 32'(i)); end
      total++; if (pc_out !== 32'h100 + 32'(i) * 4) begin bad++; $display("FAIL read_pc%0d got=%h", i, pc_out); end
      total++; if (ctrl() !== 5'b0) begin bad++; $display("FAIL read_ctrl%0d got=%b exp=00000", i, ctrl()); end
    end
  endtask

  task automatic test_add();
    instruction_in = 32'hE281_1005; pc_in = 32'h200;
    tick();
    total++; if (exe_cmd !== 4'b0010) begin bad++; $display("FAIL add_cmd got=%b exp=0010", exe_cmd); end
    total++; if (ctrl() !== 5'b10000) begin bad++; $display("FAIL add_ctrl got=%b exp=10000", ctrl()); end
    total++; if (imm !== 1'b1) begin bad++; $display("FAIL add_imm got=%b exp=1", imm); end
    total++; if (dest !== 4'd1) begin bad++; $display("FAIL add_dest got=%0d exp=1", dest); end
    total++; if (rn_val !== 32'd1) begin bad++; $display("FAIL add_rn got=%h exp=1", rn_val); end
    total++; if (two_src !== 1'b0) begin bad++; $display("FAIL add_two_src got=%b exp=0", two_src); end
    total++; if (src1 !== 4'd1) begin bad++; $display("FAIL add_src1 got=%0d exp=1", src1); end
    total++; if (shift_operand !== 12'h005) begin bad++; $display("FAIL add_shop got=%h exp=005", shift_operand); end
  endtask

  task automatic test_branch();
    instruction_in = 32'h0A00_0003; status = 4'b0000;
    tick();
    total++; if (branch !== 1'b0) begin bad++; $display("FAIL beq_z0 got=%b exp=0", branch); end
    status = 4'b0100;
    #1;
    total++; if (branch !== 1'b1) begin bad++; $display("FAIL beq_z1 got=%b exp=1", branch); end
    total++; if (signed_imm_24 !== 24'h000003) begin bad++; $display("FAIL beq_imm got=%h exp=000003", signed_imm_24); end
    total++; if (exe_cmd !== 4'b0000) begin bad++; $display("FAIL beq_cmd got=%b exp=0000", exe_cmd); end
  endtask

  task automatic test_cond();
    logic [3:0] c_tab [20] = '{4'h0,4'h1,4'h2,4'h3,4'h4,4'h5,4'h6,4'h7,4'h8,4'h8,
                               4'h9,4'hA,4'hA,4'hB,4'hC,4'hC,4'hD,4'hD,4'hE,4'hF};
    logic [3:0] f_tab [20] = '{4'b0100,4'b0100,4'b0010,4'b0010,4'b1000,4'b1000,4'b0001,4'b0001,4'b0010,4'b0110,
                               4'b0110,4'b1001,4'b1000,4'b1000,4'b0000,4'b0100,4'b0100,4'b0000,4'b0000,4'b1111};
    logic       e_tab [20] = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,
                               1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
    for (int k = 0; k < 20; k++) begin
      instruction_in = (32'(c_tab[k]) << 28) | 32'h01A0_0000;
      status = f_tab[k];
      tick();
      total++; if (wb_en_out !== e_tab[k]) begin bad++; $display("FAIL cond%0d_%h got=%b exp=%b", k, c_tab[k], wb_en_out, e_tab[k]); end
      total++; if (exe_cmd !== 4'b0001) begin bad++; $display("FAIL cond%0d_cmd got=%b exp=0001", k, exe_cmd); end
    end
    status = 4'b0000;
  endtask

  task automatic test_mem();
    instruction_in = 32'hE583_2000;
    tick();
    total++; if (ctrl() !== 5'b00100) begin bad++; $display("FAIL str_ctrl got=%b exp=00100", ctrl()); end
    total++; if (src2 !== 4'd2) begin bad++; $display("FAIL str_src2 got=%0d exp=2", src2); end
    total++; if (rm_val !== 32'd2) begin bad++; $display("FAIL str_rm got=%h exp=2", rm_val); end
    total++; if (two_src !== 1'b1) begin bad++; $display("FAIL str_two_src got=%b exp=1", two_src); end
    total++; if (exe_cmd !== 4'b0010) begin bad++; $display("FAIL str_cmd got=%b exp=0010", exe_cmd); end
    instruction_in = 32'hE593_2000;
    tick();
    total++; if (ctrl() !== 5'b11000) begin bad++; $display("FAIL ldr_ctrl got=%b exp=11000", ctrl()); end
    total++; if (exe_cmd !== 4'b0010) begin bad++; $display("FAIL ldr_cmd got=%b exp=0010", exe_cmd); end
  endtask

  task automatic test_freeze();
    instruction_in = 32'hE281_1005; pc_in = 32'h200;
    tick();
    freeze = 1'b1;
    instruction_in = 32'hE583_2000; pc_in = 32'h300;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (ctrl() !== 5'b10000) begin bad++; $display("FAIL frz%0d_ctrl got=%b exp=10000", k, ctrl()); end
      total++; if (pc_out !== 32'h200) begin bad++; $display("FAIL frz%0d_pc got=%h exp=200", k, pc_out); end
      instruction_in = 32'h0A00_0003;
    end
    instruction_in = 32'hE583_2000;
    freeze = 1'b0;
    tick();
    total++; if (ctrl() !== 5'b00100) begin bad++; $display("FAIL frz_rel_ctrl got=%b exp=00100", ctrl()); end
    total++; if (pc_out !== 32'h300) begin bad++; $display("FAIL frz_rel_pc got=%h exp=300", pc_out); end
  endtask

  task automatic test_flush();
    instruction_in = 32'hE291_1005;
    flush = 1'b1; freeze = 1'b1;
    tick();
    total++; if (ctrl() !== 5'b0) begin bad++; $display("FAIL flush_ctrl got=%b exp=00000", ctrl()); end
    total++; if (imm !== 1'b0) begin bad++; $display("FAIL flush_imm got=%b exp=0", imm); end
    flush = 1'b0; freeze = 1'b0;
    tick();
    total++; if (ctrl() !== 5'b10001) begin bad++; $display("FAIL flush_rec_ctrl got=%b exp=10001", ctrl()); end
  endtask

  task automatic test_bypass();
    instruction_in = 32'hEC03_0003;
    tick();
    total++; if (rn_val !== 32'd3) begin bad++; $display("FAIL byp_pre got=%h exp=3", rn_val); end
    wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD_BEEF;
    #1;
    total++; if (rn_val !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rn got=%h exp=deadbeef", rn_val); end
    total++; if (rm_val !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rm got=%h exp=deadbeef", rm_val); end
    tick();
    wb_en = 1'b0; wb_value = 32'h0;
    #1;
    total++; if (rn_val !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_kept got=%h exp=deadbeef", rn_val); end
  endtask

  task automatic test_wb15();
    logic [31:0] exp;
    wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h1234_5678;
    tick();
    wb_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp = (i == 3) ? 32'hDEAD_BEEF : 32'(i);
      instruction_in = 32'hEC00_0000 | (32'(i) << 16);
      tick();
      total++; if (rn_val !== exp) begin bad++; $display("FAIL wb15_r%0d got=%h exp=%h", i, rn_val, exp); end
    end
  endtask

  task automatic test_reset_mid();
    instruction_in = 32'hE281_1005; pc_in = 32'h400;
    tick();
    flush = 1'b1; freeze = 1'b1;
    wb_en = 1'b1; wb_dest = 4'd0; wb_value = 32'hCAFE_F00D;
    #2 rst = 1'b0;
    #1;
    total++; if (pc_out !== 32'd0) begin bad++; $display("FAIL mrst_pc got=%h exp=0", pc_out); end
    total++; if (ctrl() !== 5'b0) begin bad++; $display("FAIL mrst_ctrl got=%b exp=00000", ctrl()); end
    total++; if (rn_val !== 32'd0) begin bad++; $display("FAIL mrst_rn got=%h exp=0", rn_val); end
    tick();
    flush = 1'b0; freeze = 1'b0; wb_en = 1'b0;
    rst = 1'b1;
    instruction_in = 32'hEC03_0000;
    tick();
    total++; if (rn_val !== 32'd3) begin bad++; $display("FAIL mrst_r3 got=%h exp=3", rn_val); end
  endtask

  initial begin
    test_reset();
    test_read_all();
    test_add();
    test_branch();
    test_cond();
    test_mem();
    test_freeze();
    test_flush();
    test_bypass();
    test_wb15();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
